// File: rtl/cpu_writeback.sv
// cpu_writeback: writeback stage feeding the single register-file write port.
//
// Two sources compete for the write port: ALU results and load responses.
// Loads win by default. An ALU result that has lost ALU_STARVE_MAX cycles
// in a row is forced through on the next cycle. Load data is aligned and
// then sign- or zero-extended. One write is registered per cycle. Every
// accepted transfer is counted in wb_instret.
//
// Optional feature macro: CPU_WB_BYPASS_EN
//   When defined, the in-flight write is forwarded to the operand reads.
//   When undefined, the regfile read data passes straight through.
//
// Ports
//   clk, reset                   rising-edge clock, asynchronous active-low reset
//   alu_valid/ready/rd/data      ALU result handshake
//   ld_valid/ready/rd/data       load response handshake
//   ld_funct3, ld_byte_off       load type and byte offset of the datum
//   rd_addr/rd_data/rd_write_en  regfile write port
//   wb_instret                   64-bit count of accepted writebacks
//   byp_rs1/2_addr               operand read addresses
//   rf_rs1/2_data                regfile read data
//   byp_rs1/2_data               forwarded operand data
module cpu_writeback #(
  parameter int XLEN           = 32,
  parameter int ALU_STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [4:0]                    ld_rd,
  input  logic [XLEN-1:0]               ld_data,
  input  logic [2:0]                    ld_funct3,
  input  logic [$clog2(XLEN/8)-1:0]     ld_byte_off,
  output logic [4:0]                    rd_addr,
  output logic [XLEN-1:0]               rd_data,
  output logic                          rd_write_en,
  output logic [63:0]                   wb_instret,
  input  logic [4:0]                    byp_rs1_addr,
  input  logic [4:0]                    byp_rs2_addr,
  input  logic [XLEN-1:0]               rf_rs1_data,
  input  logic [XLEN-1:0]               rf_rs2_data,
  output logic [XLEN-1:0]               byp_rs1_data,
  output logic [XLEN-1:0]               byp_rs2_data
);

  localparam int OFF_W = $clog2(XLEN/8);
  localparam int SC_W  = $clog2(ALU_STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(ALU_STARVE_MAX);

  // Shift the datum down to bit 0, then extend it according to funct3.
  // Illegal encodings return 0; the write still retires.
  function automatic logic [XLEN-1:0] fmt_load(
    input logic [XLEN-1:0]  raw,
    input logic [OFF_W-1:0] off,
    input logic [2:0]       f3
  );
    logic [XLEN-1:0]    sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    logic [7:0]         b_u;
    logic [15:0]        h_u;
    logic [31:0]        w_u;
    sh  = raw >> {off, 3'b000};
    b_u = sh[7:0];
    h_u = sh[15:0];
    w_u = sh[31:0];
    b_s = b_u;
    h_s = h_u;
    w_s = w_u;
    case (f3)
      3'b000:  fmt_load = XLEN'(b_s);
      3'b001:  fmt_load = XLEN'(h_s);
      3'b010:  fmt_load = XLEN'(w_s);
      3'b011:  fmt_load = (XLEN == 64) ? sh : '0;
      3'b100:  fmt_load = XLEN'(b_u);
      3'b101:  fmt_load = XLEN'(h_u);
      3'b110:  fmt_load = (XLEN == 64) ? XLEN'(w_u) : '0;
      default: fmt_load = '0;
    endcase
  endfunction

  logic [SC_W-1:0] starve_cnt;
  logic            starve_force;
  logic            xfer_p0;
  logic [4:0]      rd_p0;
  logic [XLEN-1:0] data_p0;
  logic            vld_p1;
  logic [4:0]      rd_p1;
  logic [XLEN-1:0] data_p1;
  logic [63:0]     instret;

  // ---- Stage p0: arbitration and load formatting ----
  // The ready outputs are held at 0 while reset is asserted.
  always_comb begin
    starve_force = alu_valid && (starve_cnt == STARVE_MAX);
    ld_ready     = reset && ld_valid && !starve_force;
    alu_ready    = reset && alu_valid && !ld_ready;
    xfer_p0      = ld_ready || alu_ready;
    rd_p0        = ld_ready ? ld_rd : alu_rd;
    data_p0      = ld_ready ? fmt_load(ld_data, ld_byte_off, ld_funct3) : alu_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!alu_valid || alu_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ---- Stage p1: registered write presented to the regfile ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
      instret <= '0;
    end else begin
      vld_p1 <= xfer_p0;
      if (xfer_p0) begin
        rd_p1   <= rd_p0;
        data_p1 <= data_p0;
        instret <= instret + 64'd1;
      end
    end
  end

  assign rd_addr     = rd_p1;
  assign rd_data     = data_p1;
  assign rd_write_en = vld_p1 && (rd_p1 != 5'd0);
  assign wb_instret  = instret;

`ifdef CPU_WB_BYPASS_EN
  // The regfile returns the old value during the cycle it is written,
  // so the pending write is forwarded to any matching operand read.
  assign byp_rs1_data = (rd_write_en && (byp_rs1_addr == rd_p1)) ? data_p1 : rf_rs1_data;
  assign byp_rs2_data = (rd_write_en && (byp_rs2_addr == rd_p1)) ? data_p1 : rf_rs2_data;
`else
  logic unused_byp;
  assign unused_byp   = ^{byp_rs1_addr, byp_rs2_addr};
  assign byp_rs1_data = rf_rs1_data;
  assign byp_rs2_data = rf_rs2_data;
`endif

endmodule

// File: tb/tb_cpu_writeback.sv
module tb_cpu_writeback;

  localparam int XLEN = 32;

  logic              clk;
  logic              reset;
  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [4:0]        ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_byte_off;
  logic [4:0]        rd_addr;
  logic [XLEN-1:0]   rd_data;
  logic              rd_write_en;
  logic [63:0]       wb_instret;
  logic [4:0]        byp_rs1_addr;
  logic [4:0]        byp_rs2_addr;
  logic [XLEN-1:0]   rf_rs1_data;
  logic [XLEN-1:0]   rf_rs2_data;
  logic [XLEN-1:0]   byp_rs1_data;
  logic [XLEN-1:0]   byp_rs2_data;

  cpu_writeback #(.XLEN(XLEN), .ALU_STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_funct3(ld_funct3), .ld_byte_off(ld_byte_off),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_write_en(rd_write_en),
    .wb_instret(wb_instret),
    .byp_rs1_addr(byp_rs1_addr), .byp_rs2_addr(byp_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .byp_rs1_data(byp_rs1_data), .byp_rs2_data(byp_rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            xfer;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t         sb[$];
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  int          tb_starve = 0;
  logic [63:0] exp_instret = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One directed cycle. Inputs are driven just after a rising edge.
  // The ready outputs are checked against the arbitration model before
  // the next edge. The expected write is queued, then popped and
  // compared one cycle later.
  task automatic step(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldd,
                      input logic [2:0] f3, input logic [1:0] off,
                      input logic [XLEN-1:0] ld_exp, output logic alu_got);
    logic g_ld, g_alu;
    wb_t  e, got;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd; ld_funct3 = f3; ld_byte_off = off;
    #1;
    g_ld  = lv && !(av && tb_starve == 4);
    g_alu = av && !g_ld;
    chk("ld_ready", ld_ready, g_ld);
    chk("alu_ready", alu_ready, g_alu);
    alu_got = alu_ready;
    e.xfer = g_ld || g_alu;
    e.rd   = g_ld ? lrd : ard;
    e.data = g_ld ? ld_exp : ad;
    sb.push_back(e);
    if (e.xfer) exp_instret = exp_instret + 64'd1;
    if (av && !g_alu) tb_starve = (tb_starve == 4) ? 4 : tb_starve + 1;
    else tb_starve = 0;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("rd_write_en", rd_write_en, got.xfer && (got.rd != 5'd0));
    if (got.xfer) begin
      chk("rd_addr", rd_addr, got.rd);
      chk("rd_data", rd_data, got.data);
    end
    chk("wb_instret", wb_instret, exp_instret);
  endtask

  logic       g;
  logic [9:0] alu_win_pat;

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = '0; ld_funct3 = 3'b010; ld_byte_off = '0;
    byp_rs1_addr = '0; byp_rs2_addr = '0;
    rf_rs1_data = 32'h55; rf_rs2_data = 32'h66;
    #3;
    chk("reset_ld_ready", ld_ready, 1'b0);
    chk("reset_we", rd_write_en, 1'b0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_instret", wb_instret, 64'd0);
    chk("reset_byp1", byp_rs1_data, 32'h55);
    chk("reset_byp2", byp_rs2_data, 32'h66);
    ld_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_we", rd_write_en, 1'b0);

    // ALU only
    step(1, 5'd5, 32'h1234, 0, 5'd0, '0, 3'b000, 2'd0, '0, g);

    // Load formatting
    step(0, 5'd0, '0, 1, 5'd1, 32'h80FF7F01, 3'b000, 2'd3, 32'hFFFFFF80, g);
    step(0, 5'd0, '0, 1, 5'd2, 32'h80FF7F01, 3'b100, 2'd3, 32'h00000080, g);
    step(0, 5'd0, '0, 1, 5'd3, 32'h80FF7F01, 3'b001, 2'd2, 32'hFFFF80FF, g);
    step(0, 5'd0, '0, 1, 5'd4, 32'h80FF7F01, 3'b101, 2'd0, 32'h00007F01, g);
    step(0, 5'd0, '0, 1, 5'd6, 32'h80FF7F01, 3'b010, 2'd0, 32'h80FF7F01, g);
    step(0, 5'd0, '0, 1, 5'd8, 32'h7F017F01, 3'b001, 2'd1, 32'h0000017F, g);
    // Illegal at XLEN=32: LD, LWU, 111
    step(0, 5'd0, '0, 1, 5'd11, 32'h80FF7F01, 3'b011, 2'd0, 32'h0, g);
    step(0, 5'd0, '0, 1, 5'd13, 32'h80FF7F01, 3'b110, 2'd0, 32'h0, g);
    step(0, 5'd0, '0, 1, 5'd14, 32'h80FF7F01, 3'b111, 2'd0, 32'h0, g);

    // Starvation: expected grants L,L,L,L,A,L,L,L,L,A (bit i = ALU wins)
    alu_win_pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      step(1, 5'd9, 32'hA5A5, 1, 5'd10, 32'h1000 + i, 3'b010, 2'd0, 32'h1000 + i, g);
      chk($sformatf("starve_grant_%0d", i), g, alu_win_pat[i]);
    end

    // x0 destination: no write, still retires
    step(0, 5'd0, '0, 1, 5'd0, 32'h12345678, 3'b010, 2'd0, 32'h12345678, g);
    // idle cycle
    step(0, 5'd0, '0, 0, 5'd0, '0, 3'b000, 2'd0, '0, g);

    // Bypass of the pending write
    step(1, 5'd7, 32'hDEAD, 0, 5'd0, '0, 3'b000, 2'd0, '0, g);
    alu_valid = 1'b0;
    byp_rs1_addr = 5'd7; rf_rs1_data = 32'h1;
    byp_rs2_addr = 5'd8; rf_rs2_data = 32'h2;
    #1;
`ifdef CPU_WB_BYPASS_EN
    chk("byp_rs1_hit", byp_rs1_data, 32'hDEAD);
`else
    chk("byp_rs1_pass", byp_rs1_data, 32'h1);
`endif
    chk("byp_rs2_miss", byp_rs2_data, 32'h2);

    // Reset mid-operation with a write pending
    @(posedge clk);
    #1;
    step(1, 5'd12, 32'hBEEF, 0, 5'd0, '0, 3'b000, 2'd0, '0, g);
    alu_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_we", rd_write_en, 1'b0);
    chk("midreset_instret", wb_instret, 64'd0);
    chk("midreset_rd_data", rd_data, 32'h0);
    tb_starve = 0;
    exp_instret = 64'd0;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1, 5'd15, 32'hCAFE, 0, 5'd0, '0, 3'b000, 2'd0, '0, g);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
